// File: rtl/rx_reply_arbiter.sv
// Purpose: shares the rx reply write port between two message sources, one whole message per grant.
// Latency: grant 1 cycle after req; accepted line appears on rx_WR/rx_databus 1 cycle later.
// Backpressure: ready0/ready1 follow rx_WR_enabled combinationally; stalled cycles count toward the timeout.
//
// Ports:
//   txclk, reset_n                  clock, asynchronous active-low reset
//   reqN, wrN, dataN, doneN         source N message request, line strobe, line data, end of message
//   gntN, readyN                    source N owns the port / a write this cycle is accepted
//   rx_WR_enabled                   downstream buffer can take a line
//   rx_databus, rx_WR, rx_WR_done   registered line bus, write strobe, message-close pulse
//   timeout_err, overflow           stall-timeout pulse, sticky dropped-line flag (cleared on grant)
//   active_src                      current or most recently granted source
module rx_reply_arbiter #(
    parameter int MAX_LINES = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic        txclk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic        done0,
    input  logic        done1,
    output logic        ready0,
    output logic        ready1,
    input  logic        rx_WR_enabled,
    output logic [15:0] rx_databus,
    output logic        rx_WR,
    output logic        rx_WR_done,
    output logic        timeout_err,
    output logic        overflow,
    output logic        active_src
);

    localparam int              LCW    = $clog2(MAX_LINES + 1);
    localparam logic [LCW-1:0]  LMAX   = MAX_LINES[LCW-1:0];
    localparam logic [7:0]      TO_LIM = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           last, last_nxt;
    logic           src_nxt;
    logic [LCW-1:0] line_cnt, line_nxt;
    logic [7:0]     stall_cnt, stall_nxt, stall_inc;
    logic           wr_nxt, wdone_nxt, to_nxt, ovf_nxt;
    logic [15:0]    dat_nxt;

    // Only the granted source's strobes are looked at.
    logic           sel_req, sel_wr, sel_done, acc;
    logic [15:0]    sel_data;

    assign sel_req  = active_src ? req1  : req0;
    assign sel_wr   = active_src ? wr1   : wr0;
    assign sel_done = active_src ? done1 : done0;
    assign sel_data = active_src ? data1 : data0;

    assign gnt0   = (state == BUSY) & ~active_src;
    assign gnt1   = (state == BUSY) &  active_src;
    assign ready0 = gnt0 & rx_WR_enabled;
    assign ready1 = gnt1 & rx_WR_enabled;
    assign acc    = (state == BUSY) & sel_wr & rx_WR_enabled;

    // Saturating stall count for a cycle without an accepted write.
    assign stall_inc = (stall_cnt == TO_LIM) ? stall_cnt : stall_cnt + 8'd1;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        src_nxt   = active_src;
        line_nxt  = line_cnt;
        stall_nxt = stall_cnt;
        wr_nxt    = 1'b0;
        dat_nxt   = rx_databus;
        wdone_nxt = 1'b0;
        to_nxt    = 1'b0;
        ovf_nxt   = overflow;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    // On a tie the source that did not have the last message wins.
                    src_nxt   = (req0 & req1) ? ~last : req1;
                    line_nxt  = '0;
                    stall_nxt = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (acc) begin
                    stall_nxt = '0;
                    if (line_cnt != LMAX) begin
                        wr_nxt   = 1'b1;
                        dat_nxt  = sel_data;
                        line_nxt = line_cnt + LCW'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end else begin
                    stall_nxt = stall_inc;
                end
                if (sel_done || !sel_req) begin
                    state_nxt = CLOSE;
                end else if (!acc && stall_inc == TO_LIM) begin
                    to_nxt    = 1'b1;
                    state_nxt = CLOSE;
                end
            end
            CLOSE: begin
                // Zero-line messages close without a done pulse.
                wdone_nxt = (line_cnt != '0);
                last_nxt  = active_src;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            active_src  <= 1'b0;
            line_cnt    <= '0;
            stall_cnt   <= '0;
            rx_WR       <= 1'b0;
            rx_databus  <= 16'h0000;
            rx_WR_done  <= 1'b0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            active_src  <= src_nxt;
            line_cnt    <= line_nxt;
            stall_cnt   <= stall_nxt;
            rx_WR       <= wr_nxt;
            rx_databus  <= dat_nxt;
            rx_WR_done  <= wdone_nxt;
            timeout_err <= to_nxt;
            overflow    <= ovf_nxt;
        end
    end

endmodule
